// File: rtl/hazard_ctrl_param_if.sv
// Purpose: bundles the hazard controller's pipeline-facing inputs and control outputs.
// Latency: none; this file only declares wires.
// Backpressure: carries the dmem handshake (dmem_req_mem/dmem_resp) that freezes the pipe.
//
// Port summary:
//   inputs to controller : imem_resp, dmem_resp, dmem_req_mem, rs1_id, rs2_id,
//                          ex_is_load, rd_ex, mispredict_ex
//   outputs of controller: pc_en, stage_en, stage_flush, predict_en, mispredict_pulse,
//                          perf_stall, perf_mispred, perf_lu
//   modport master = pipeline datapath side, modport slave = hazard controller side.
interface hazard_ctrl_param_if #(
    parameter int NUM_PREGS = 4,
    parameter int REG_W     = 5,
    parameter int CNT_W     = 32
);
    logic                 imem_resp;
    logic                 dmem_resp;
    logic                 dmem_req_mem;
    logic [REG_W-1:0]     rs1_id;
    logic [REG_W-1:0]     rs2_id;
    logic                 ex_is_load;
    logic [REG_W-1:0]     rd_ex;
    logic                 mispredict_ex;

    logic                 pc_en;
    logic [NUM_PREGS-1:0] stage_en;
    logic [NUM_PREGS-1:0] stage_flush;
    logic                 predict_en;
    logic                 mispredict_pulse;
    logic [CNT_W-1:0]     perf_stall;
    logic [CNT_W-1:0]     perf_mispred;
    logic [CNT_W-1:0]     perf_lu;

    modport master (
        output imem_resp, dmem_resp, dmem_req_mem, rs1_id, rs2_id,
               ex_is_load, rd_ex, mispredict_ex,
        input  pc_en, stage_en, stage_flush, predict_en, mispredict_pulse,
               perf_stall, perf_mispred, perf_lu
    );

    modport slave (
        input  imem_resp, dmem_resp, dmem_req_mem, rs1_id, rs2_id,
               ex_is_load, rd_ex, mispredict_ex,
        output pc_en, stage_en, stage_flush, predict_en, mispredict_pulse,
               perf_stall, perf_mispred, perf_lu
    );
endinterface

// File: rtl/hazard_ctrl_param.sv
// Purpose: pipeline hazard controller (freeze, redirect/flush, load-use bubbles, wrong-path kill).
// Latency: control outputs are combinational from state and inputs; state advances each clk edge.
// Backpressure: a pending dmem access without response freezes every stage and holds all state.
//
// Ports: clk, rst_n (async active-low; forces every output to 0 while low),
//        hz (hazard_ctrl_param_if.slave) carrying all handshake inputs and control outputs.
// Optional feature: define HAZARD_PERF_CNT_EN to build the saturating perf counters;
//        otherwise perf_stall/perf_mispred/perf_lu are tied to 0 and no counter flops exist.
module hazard_ctrl_param #(
    parameter int NUM_PREGS   = 4,
    parameter int FLUSH_DEPTH = 2,
    parameter int LU_STALLS   = 1,
    parameter int REG_W       = 5,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_ctrl_param_if.slave hz
);

    typedef enum logic [1:0] {RUN, LU_STALL, KILL} state_t;

    localparam logic [NUM_PREGS-1:0] ALL_EN     = {NUM_PREGS{1'b1}};
    localparam logic [NUM_PREGS-1:0] FLUSH_MASK = {NUM_PREGS{1'b1}} >> (NUM_PREGS - FLUSH_DEPTH);
    localparam logic [NUM_PREGS-1:0] BIT0       = NUM_PREGS'(1);
    localparam logic [NUM_PREGS-1:0] BIT1       = NUM_PREGS'(2);
    localparam logic [3:0]           LU_LOAD    = 4'(LU_STALLS - 1);

    state_t               r_state;
    logic [3:0]           r_lu_cnt;

    logic                 w_backend_ok;
    logic                 w_if_ok;
    logic                 w_lu_hit;
    logic                 w_in_lu;
    logic                 w_lu_entry;
    logic                 w_pc_en;
    logic [NUM_PREGS-1:0] w_stage_en;
    logic [NUM_PREGS-1:0] w_stage_flush;
    logic                 w_pulse;

    always_comb begin
        w_backend_ok  = hz.dmem_resp | ~hz.dmem_req_mem;
        w_if_ok       = hz.imem_resp & (r_state != KILL);
        w_lu_hit      = hz.ex_is_load & (hz.rd_ex != REG_W'(0)) &
                        ((hz.rd_ex == hz.rs1_id) | (hz.rd_ex == hz.rs2_id));
        // KILL deliberately skips load-use: the IF/ID contents are a bubble anyway.
        w_in_lu       = (r_state == LU_STALL) | ((r_state == RUN) & w_lu_hit);
        w_lu_entry    = w_backend_ok & ~hz.mispredict_ex & (r_state == RUN) & w_lu_hit;

        w_pc_en       = 1'b0;
        w_stage_en    = '0;
        w_stage_flush = '0;
        w_pulse       = 1'b0;

        if (!w_backend_ok) begin
            // full freeze: defaults already zero
        end else if (hz.mispredict_ex) begin
            w_stage_en    = ALL_EN;
            w_stage_flush = FLUSH_MASK;
            w_pc_en       = 1'b1;
            w_pulse       = 1'b1;
        end else if (w_in_lu) begin
            // hold IF/ID and PC, push a bubble into ID/EX
            w_stage_en    = ALL_EN & ~BIT0;
            w_stage_flush = BIT1;
        end else if (w_if_ok) begin
            w_stage_en    = ALL_EN;
            w_pc_en       = 1'b1;
        end else begin
            // nothing usable fetched (or discarding the wrong-path fetch)
            w_stage_en    = ALL_EN;
            w_stage_flush = BIT0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_lu_cnt <= 4'd0;
        end else if (w_backend_ok) begin
            if (hz.mispredict_ex) begin
                r_lu_cnt <= 4'd0;
                // A redirect with no response this cycle leaves the old fetch in flight;
                // redirecting again from KILL still has a stale fetch outstanding.
                r_state  <= (!hz.imem_resp || r_state == KILL) ? KILL : RUN;
            end else if (w_in_lu) begin
                if (r_state == RUN) begin
                    r_lu_cnt <= LU_LOAD;
                    r_state  <= (LU_STALLS > 1) ? LU_STALL : RUN;
                end else begin
                    // lu_cnt counts the bubbles still owed after this one
                    if (r_lu_cnt != 4'd0) r_lu_cnt <= r_lu_cnt - 4'd1;
                    if (r_lu_cnt <= 4'd1) r_state <= RUN;
                end
            end else if (r_state == KILL && hz.imem_resp) begin
                r_state <= RUN;
            end
        end
    end

    assign hz.pc_en            = rst_n & w_pc_en;
    assign hz.stage_en         = w_stage_en & {NUM_PREGS{rst_n}};
    assign hz.stage_flush      = w_stage_flush & {NUM_PREGS{rst_n}};
    assign hz.predict_en       = rst_n & (w_stage_en[0] | w_stage_en[1]);
    assign hz.mispredict_pulse = rst_n & w_pulse;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_stall;
    logic [CNT_W-1:0] r_perf_mispred;
    logic [CNT_W-1:0] r_perf_lu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_stall   <= '0;
            r_perf_mispred <= '0;
            r_perf_lu      <= '0;
        end else begin
            if (!w_pc_en && r_perf_stall != {CNT_W{1'b1}})
                r_perf_stall <= r_perf_stall + CNT_W'(1);
            if (w_pulse && r_perf_mispred != {CNT_W{1'b1}})
                r_perf_mispred <= r_perf_mispred + CNT_W'(1);
            if (w_lu_entry && r_perf_lu != {CNT_W{1'b1}})
                r_perf_lu <= r_perf_lu + CNT_W'(1);
        end
    end

    assign hz.perf_stall   = r_perf_stall;
    assign hz.perf_mispred = r_perf_mispred;
    assign hz.perf_lu      = r_perf_lu;
`else
    assign hz.perf_stall   = {CNT_W{1'b0}};
    assign hz.perf_mispred = {CNT_W{1'b0}};
    assign hz.perf_lu      = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/hazard_ctrl_param.md
Name: hazard_ctrl_param

Overview:
- Parametrised pipeline hazard controller for the rv32i pipelined CPU; the next generation of the single-cycle hazard logic.
- Generates PC enable, per-pipeline-register enables and flushes, and the branch-predictor enable from memory handshakes, EX-stage mispredict and load-use detection.
- Adds configurable pipeline depth, flush depth and multi-cycle load-use bubbles.
- Adds a KILL state that discards a wrong-path instruction fetch still in flight at redirect, and optional performance counters.

Parameters:
- NUM_PREGS, 4, number of pipeline registers; index 0=IF/ID, 1=ID/EX, 2=EX/MEM, 3+=later. Minimum 4.
- FLUSH_DEPTH, 2, number of front pipeline registers (indices 0..FLUSH_DEPTH-1) flushed on mispredict. Range 1..NUM_PREGS-1.
- LU_STALLS, 1, bubble cycles inserted per load-use hazard. Range 1..15.
- REG_W, 5, register-index width.
- CNT_W, 32, performance-counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_resp  in  1  instruction memory response valid.
- dmem_resp  in  1  data memory response valid.
- dmem_req_mem  in  1  MEM stage has a read or write outstanding.
- rs1_id  in  REG_W  ID-stage source register 1.
- rs2_id  in  REG_W  ID-stage source register 2.
- ex_is_load  in  1  EX-stage instruction is a load.
- rd_ex  in  REG_W  EX-stage destination register.
- mispredict_ex  in  1  EX resolved a misprediction or jump redirect; held until acted on.
- pc_en  out  1  PC load enable.
- stage_en  out  NUM_PREGS  pipeline-register enables.
- stage_flush  out  NUM_PREGS  pipeline-register flush (load a bubble when enabled).
- predict_en  out  1  branch-predictor update enable.
- mispredict_pulse  out  1  one cycle per redirect actually taken.
- perf_stall  out  CNT_W  stall-cycle count.
- perf_mispred  out  CNT_W  mispredict count.
- perf_lu  out  CNT_W  load-use event count.

Behaviour:
- Definitions:
  - backend_ok = dmem_resp | ~dmem_req_mem.
  - if_ok = imem_resp & (state != KILL).
  - lu_hit = ex_is_load & (rd_ex != 0) & ((rd_ex == rs1_id) | (rd_ex == rs2_id)). Register x0 never causes a stall.
- State machine states: RUN, LU_STALL, KILL. A 4-bit bubble counter lu_cnt.
- Reset:
  - state=RUN, lu_cnt=0, counters=0.
  - While rst_n is low, all outputs are forced to 0.
- Outputs are combinational from state and inputs. Priority, highest first:
  1. ~backend_ok: all stage_en=0, pc_en=0, flush=0 (full freeze). State and lu_cnt hold.
  2. mispredict_ex:
     - all stage_en=1, flush[0..FLUSH_DEPTH-1]=1, pc_en=1, mispredict_pulse=1, lu_cnt cleared.
     - Next state KILL if imem_resp=0 this cycle (a wrong-path fetch is still in flight), else RUN.
     - A mispredict in KILL re-enters KILL.
  3. state==LU_STALL or (state==RUN & lu_hit):
     - all stage_en=1 except stage_en[0]=0; stage_flush[1]=1; pc_en=0.
     - On entry from RUN: lu_cnt loads LU_STALLS-1, and the next state is LU_STALL only if LU_STALLS>1.
     - In LU_STALL: lu_cnt decrements each cycle; return to RUN on the cycle lu_cnt==0.
  4. if_ok: all stage_en=1, pc_en=1 (normal advance).
  5. Otherwise (no instruction fetched or KILL): all stage_en=1, stage_flush[0]=1, pc_en=0, so a bubble enters IF/ID.
     - In KILL, the first imem_resp is discarded and the state moves to RUN the following cycle.
- predict_en = stage_en[0] | stage_en[1].
- Simultaneous events:
  - A mispredict overrides load-use.
  - A dmem stall overrides everything; a pending mispredict waits because EX is frozen and holds mispredict_ex.
- Reset asserted mid-stall or in KILL returns the block to RUN immediately (asynchronous).

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - perf_stall increments on each cycle where pc_en=0 and the block is not in reset.
  - perf_mispred increments on each mispredict_pulse.
  - perf_lu increments on each RUN->load-use entry.
  - All counters saturate at all-ones.
- Undefined: all three counters are tied to 0 and no counter flops are instantiated.

Test Plan:
- Reset, then imem_resp=1, dmem_req_mem=0 steady -> pc_en=1, stage_en=4'b1111, flush=0 every cycle. Reset forces all outputs to 0 asynchronously.
- LU_STALLS=3: ex_is_load=1, rd_ex=5, rs1_id=5 -> 3 consecutive cycles with stage_en[0]=0, stage_flush[1]=1, pc_en=0, then RUN; with rd_ex=0 -> no stall.
- mispredict_ex=1 with imem_resp=0 -> flush=4'b0011, pc_en=1, pulse=1. The next imem_resp is ignored (flush[0]=1, pc_en=0), then normal fetch resumes.
- dmem_req_mem=1, dmem_resp=0 for 4 cycles while mispredict_ex=1 -> full freeze for 4 cycles; redirect occurs in the cycle dmem_resp=1.
- HAZARD_PERF_CNT_EN, CNT_W=4: 20 mispredicts -> perf_mispred saturates at 15.
